// File: rtl/key10_debounce.sv
// key10_debounce: synchronizes the raw keypad lines and debounces them as one
// vector. The debounced vector drives the BCD priority encoder; press/release
// strobes mark transitions between the all-zero and non-zero key vectors.
module key10_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             o_press,
  output logic             o_release
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_COUNT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Two-flop synchronizer; only s2_q is used past this point.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i;
      s2_q <= s1_q;
    end
  end

  // Debounce state, candidate, counter, output vector and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any change at s2 (re)loads the candidate and restarts the count; once the
  // candidate has held for the full window it is copied to the output. The
  // strobes only care about the all-zero boundary, so roll-over between
  // non-zero vectors (or a bounce back to the old value) is silent.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          o_d       = cand_q;
          press_d   = (o_q == '0) && (cand_q != '0);
          release_d = (o_q != '0) && (cand_q == '0);
          state_d   = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  assign o         = o_q;
  assign o_press   = press_q;
  assign o_release = release_q;

endmodule

// File: tb/tb_key10_debounce.sv
// Bench for key10_debounce: directed scenarios followed by random key patterns,
// compared every cycle against a history-window reference model.
module tb_key10_debounce;
  localparam int W = 10;
  localparam int D = 4;
  localparam int HN = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i;
  logic [W-1:0] o;
  logic         o_press, o_release;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: hist[k] is the value the first sync stage holds after
  // edge k (0 on reset edges). The output takes value v at edge k exactly when
  // hist[k-D-3] differs from v and hist[k-D-2..k-2] all equal v.
  logic [W-1:0] hist [0:HN-1];
  int           k;
  logic [W-1:0] exp_o;
  logic         exp_press, exp_rel;

  key10_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .i(i), .o(o), .o_press(o_press), .o_release(o_release)
  );

  always #5 clk = ~clk;

  task automatic check_outputs();
    n_checks++;
    assert (o === exp_o) else begin
      n_fail++;
      $error("FAIL o edge=%0d got=%h exp=%h", k, o, exp_o);
    end
    n_checks++;
    assert (o_press === exp_press) else begin
      n_fail++;
      $error("FAIL o_press edge=%0d got=%b exp=%b", k, o_press, exp_press);
    end
    n_checks++;
    assert (o_release === exp_rel) else begin
      n_fail++;
      $error("FAIL o_release edge=%0d got=%b exp=%b", k, o_release, exp_rel);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] v);
    logic         run_ok;
    logic [W-1:0] cv;
    rst = r;
    i   = v;
    @(posedge clk);
    k++;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    if (r) begin
      for (int j = k - D - 3; j <= k; j++) hist[j] = '0;
      exp_o = '0;
    end else begin
      hist[k] = v;
      cv      = hist[k-2];
      run_ok  = (hist[k-D-3] != cv);
      for (int j = k - D - 2; j <= k - 2; j++)
        if (hist[j] != cv) run_ok = 1'b0;
      if (run_ok) begin
        exp_press = (exp_o == '0) && (cv != '0);
        exp_rel   = (exp_o != '0) && (cv == '0);
        exp_o     = cv;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic r, input logic [W-1:0] v, input int n);
    for (int c = 0; c < n; c++) step(r, v);
  endtask

  initial begin
    for (int j = 0; j < HN; j++) hist[j] = '0;
    k         = 16;
    exp_o     = '0;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    rst       = 1'b1;
    i         = '0;

    // Reset held with all keys pressed, then released with keys still held.
    hold(1'b1, 10'h3FF, 3);
    hold(1'b0, 10'h3FF, 10);

    // Return to idle, then a clean single-key press.
    hold(1'b0, 10'h000, 10);
    hold(1'b0, 10'b0000001000, 10);
    hold(1'b0, 10'h000, 10);

    // Bit 0 bouncing every 2 cycles, then settling high.
    for (int b = 0; b < 6; b++) begin
      hold(1'b0, 10'b1, 2);
      hold(1'b0, 10'b0, 2);
    end
    hold(1'b0, 10'b1, 10);
    hold(1'b0, 10'h000, 10);

    // Release from a single pressed key.
    hold(1'b0, 10'b0100000000, 10);
    hold(1'b0, 10'h000, 10);

    // Roll-over between non-zero vectors: no strobes expected.
    hold(1'b0, 10'b0000000100, 10);
    hold(1'b0, 10'b0000010000, 10);
    hold(1'b0, 10'b1100000000, 10);

    // Short glitch back to the old value mid-count: output rewritten silently.
    hold(1'b0, 10'b0000000001, 2);
    hold(1'b0, 10'b1100000000, 10);
    hold(1'b0, 10'h000, 10);

    // Reset in the middle of a count, then recovery with the key held.
    hold(1'b0, 10'b10, 4);
    hold(1'b1, 10'b10, 1);
    hold(1'b0, 10'b10, 10);
    hold(1'b0, 10'h000, 10);

    // Random key vectors with random hold times; occasional reset.
    for (int n = 0; n < 250; n++) begin
      logic [W-1:0] rv;
      logic         rr;
      rv = W'($urandom);
      if ($urandom_range(0, 2) == 0) rv = '0;
      rr = ($urandom_range(0, 40) == 0);
      hold(rr, rv, $urandom_range(1, 8));
    end
    hold(1'b0, 10'h000, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
